// File: rtl/eth_rx_pkg.sv
// Shared constants and types for the GMII receive MAC and its CRC helper.
package eth_rx_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  localparam int ST_PHY   = 0;
  localparam int ST_SHORT = 1;
  localparam int ST_LONG  = 2;
  localparam int ST_CRC   = 3;

  // Payload delay line: one output byte plus the 4 FCS bytes still in flight.
  localparam int BUF_DEPTH = 5;
  localparam int LEN_W     = 11;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_e;
endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide CRC-32 step, reflected polynomial, LSB first.
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  logic [31:0] c;

  always_comb begin
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
  end

  assign crc_next = c;
endmodule

// File: rtl/gmii_rx_mac.sv
// GMII receive framer: strips preamble/SFD, checks FCS/length/PHY error,
// drops the FCS and streams payload with per-frame status and frame counters.
module gmii_rx_mac
  import eth_rx_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic             gmii_rx_clk,
  input  logic             rst_n,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_last,
  output logic [3:0]       rx_status,
  output logic             rx_good,
  output logic [CNT_W-1:0] stat_ok_cnt,
  output logic [CNT_W-1:0] stat_bad_cnt
);
  localparam logic [LEN_W-1:0] MAX_LEN_C = MAX_LEN[LEN_W-1:0];
  localparam logic [LEN_W-1:0] MIN_LEN_C = MIN_LEN[LEN_W-1:0];
  localparam logic [2:0]       FULL      = 3'(BUF_DEPTH);

  rx_state_e        state;
  logic [7:0]       byte_buf [BUF_DEPTH];
  logic [2:0]       fill;
  logic [LEN_W-1:0] byte_cnt;
  logic [31:0]      crc_q;
  logic [31:0]      crc_next;
  logic             phy_err;
  logic [3:0]       status_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  crc32_d8 u_crc (
    .crc      (crc_q),
    .data     (gmii_rxd),
    .crc_next (crc_next)
  );

  always_comb begin
    status_c           = '0;
    status_c[ST_CRC]   = (crc_q != CRC_RESIDUE);
    status_c[ST_LONG]  = (byte_cnt > MAX_LEN_C);
    status_c[ST_SHORT] = (byte_cnt < MIN_LEN_C);
    status_c[ST_PHY]   = phy_err;
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fill         <= '0;
      byte_cnt     <= '0;
      crc_q        <= '0;
      phy_err      <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) byte_buf[i] <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_last      <= 1'b0;
      rx_status    <= '0;
      rx_good      <= 1'b0;
      stat_ok_cnt  <= '0;
      stat_bad_cnt <= '0;
    end else begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_last   <= 1'b0;
      rx_status <= '0;
      rx_good   <= 1'b0;
      case (state)
        IDLE:
          if (gmii_rx_dv) state <= (gmii_rxd == PREAMBLE_BYTE) ? PREAMBLE : DROP;
        PREAMBLE:
          if (!gmii_rx_dv) begin
            state <= IDLE;
          end else if (gmii_rxd == SFD_BYTE) begin
            state    <= DATA;
            crc_q    <= CRC_INIT;
            byte_cnt <= '0;
            fill     <= '0;
            phy_err  <= 1'b0;
          end else if (gmii_rxd != PREAMBLE_BYTE) begin
            state <= DROP;
          end
        DATA:
          if (gmii_rx_dv) begin
            byte_buf[0] <= gmii_rxd;
            for (int i = 1; i < BUF_DEPTH; i++) byte_buf[i] <= byte_buf[i-1];
            crc_q <= crc_next;
            if (byte_cnt != {LEN_W{1'b1}}) byte_cnt <= byte_cnt + 1'b1;
            if (fill == FULL) begin
              rx_valid <= 1'b1;
              rx_data  <= byte_buf[BUF_DEPTH-1];
            end else begin
              fill <= fill + 3'd1;
            end
            if (gmii_rx_er) phy_err <= 1'b1;
          end else begin
            state <= IDLE;
            // Only the oldest byte is payload; the remaining four are the FCS.
            if (fill == FULL) begin
              rx_valid  <= 1'b1;
              rx_last   <= 1'b1;
              rx_data   <= byte_buf[BUF_DEPTH-1];
              rx_status <= status_c;
              rx_good   <= (status_c == 4'd0);
              if (status_c == 4'd0) stat_ok_cnt  <= sat_inc(stat_ok_cnt);
              else                  stat_bad_cnt <= sat_inc(stat_bad_cnt);
            end else begin
              stat_bad_cnt <= sat_inc(stat_bad_cnt);
            end
          end
        DROP:
          if (!gmii_rx_dv) begin
            state        <= IDLE;
            stat_bad_cnt <= sat_inc(stat_bad_cnt);
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gmii_rx_mac.sv
// Randomized and directed bench for gmii_rx_mac with a frame-level reference model.
module tb_gmii_rx_mac;
  logic        gmii_rx_clk;
  logic        rst_n;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic [3:0]  rx_status;
  logic        rx_good;
  logic [15:0] stat_ok_cnt;
  logic [15:0] stat_bad_cnt;

  gmii_rx_mac #(.MAX_LEN(1518), .MIN_LEN(64), .CNT_W(16)) dut (
    .gmii_rx_clk  (gmii_rx_clk),
    .rst_n        (rst_n),
    .gmii_rxd     (gmii_rxd),
    .gmii_rx_dv   (gmii_rx_dv),
    .gmii_rx_er   (gmii_rx_er),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_last      (rx_last),
    .rx_status    (rx_status),
    .rx_good      (rx_good),
    .stat_ok_cnt  (stat_ok_cnt),
    .stat_bad_cnt (stat_bad_cnt)
  );

  initial gmii_rx_clk = 1'b0;
  always #4 gmii_rx_clk = ~gmii_rx_clk;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic [3:0] st;
    int         due;
  } beat_t;

  // sel: 0 beats since mark, 1 last status, 2 ok cnt, 3 bad cnt, 4 pending beats, 5 given value, 9 mark
  typedef struct {
    string       name;
    int          sel;
    logic [63:0] act;
    logic [63:0] exp;
  } req_t;

  beat_t      exp_q[$];
  req_t       req_q[$];
  logic [7:0] tx_pre[$];
  logic [7:0] tx_body[$];
  int         exp_ok = 0;
  int         exp_bad = 0;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         beats_seen = 0;
  logic [3:0] last_st = '0;
  beat_t      cb;
  req_t       cr;
  logic [63:0] cact;

  always @(posedge gmii_rx_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge gmii_rx_clk) begin
    if (!rst_n) begin
      chk("reset_outputs", 64'({rx_data, rx_valid, rx_last, rx_status, rx_good,
                                stat_ok_cnt, stat_bad_cnt}), 64'(0));
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        cb = exp_q.pop_front();
        chk("beat_valid",  64'(rx_valid),  64'(1));
        chk("beat_data",   64'(rx_data),   64'(cb.d));
        chk("beat_last",   64'(rx_last),   64'(cb.last));
        chk("beat_status", 64'(rx_status), 64'(cb.st));
        chk("beat_good",   64'(rx_good),   64'(cb.last && cb.st == 4'd0));
      end else begin
        chk("no_beat", 64'({rx_valid, rx_last, rx_status, rx_good}), 64'(0));
      end
      if (rx_valid) beats_seen++;
      if (rx_last) last_st = rx_status;
      chk("ok_cnt",  64'(stat_ok_cnt),  64'(exp_ok));
      chk("bad_cnt", 64'(stat_bad_cnt), 64'(exp_bad));
      while (req_q.size() > 0) begin
        cr = req_q.pop_front();
        if (cr.sel == 9) begin
          beats_seen = 0;
          last_st    = '0;
        end else begin
          case (cr.sel)
            0:       cact = 64'(beats_seen);
            1:       cact = 64'(last_st);
            2:       cact = 64'(stat_ok_cnt);
            3:       cact = 64'(stat_bad_cnt);
            4:       cact = 64'(exp_q.size());
            default: cact = cr.act;
          endcase
          chk(cr.name, cact, cr.exp);
        end
      end
    end
  end

  task automatic req(input string nm, input int sel, input logic [63:0] exp,
                     input logic [63:0] act = '0);
    req_t r;
    r.name = nm; r.sel = sel; r.exp = exp; r.act = act;
    req_q.push_back(r);
  endtask

  task automatic mark();
    req("mark", 9, '0);
  endtask

  function automatic logic [31:0] crc32_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, tx_body[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic add_fcs();
    logic [31:0] c;
    c = crc32_of(tx_body.size());
    for (int k = 0; k < 4; k++) tx_body.push_back(c[8*k +: 8]);
  endtask

  task automatic set_pre(input int n55);
    tx_pre.delete();
    for (int i = 0; i < n55; i++) tx_pre.push_back(8'h55);
    tx_pre.push_back(8'hD5);
  endtask

  task automatic set_seq(input int n);
    tx_body.delete();
    for (int i = 0; i < n; i++) tx_body.push_back(8'(i));
  endtask

  task automatic set_rand(input int n);
    tx_body.delete();
    for (int i = 0; i < n; i++) tx_body.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    gmii_rx_dv = dv;
    gmii_rxd   = d;
    gmii_rx_er = er;
    @(posedge gmii_rx_clk);
    #1;
  endtask

  // Idle cycles carry random rxd/er, which the receiver must ignore while dv=0.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  task automatic push_beat(input logic [7:0] d, input logic last, input logic [3:0] st);
    beat_t b;
    b.d = d; b.last = last; b.st = st; b.due = cyc + 1;
    exp_q.push_back(b);
  endtask

  // Sends tx_pre then tx_body then one dv=0 cycle; expectations follow frame-level rules.
  task automatic send_frame(input int er_idx, input int rst_idx);
    int          n;
    int          first_bad;
    int          len_c;
    bit          accepted;
    bit          crc_ok;
    logic [3:0]  st;
    n = tx_body.size();
    first_bad = tx_pre.size();
    for (int i = tx_pre.size() - 1; i >= 0; i--) if (tx_pre[i] != 8'h55) first_bad = i;
    accepted = (tx_pre.size() >= 2) && (first_bad == tx_pre.size() - 1) &&
               (tx_pre[tx_pre.size() - 1] == 8'hD5);
    len_c  = (n > 2047) ? 2047 : n;
    crc_ok = (n >= 4) &&
             ({tx_body[n-1], tx_body[n-2], tx_body[n-3], tx_body[n-4]} == crc32_of(n - 4));
    st = {!crc_ok, len_c > 1518, len_c < 64, er_idx >= 0 && er_idx < n};
    foreach (tx_pre[i]) drive(1'b1, tx_pre[i], 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == rst_idx) begin
        rst_n      = 1'b0;
        gmii_rx_dv = 1'b0;
        exp_q.delete();
        exp_ok  = 0;
        exp_bad = 0;
        @(posedge gmii_rx_clk); #1;
        @(posedge gmii_rx_clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (accepted && i >= 5) push_beat(tx_body[i-5], 1'b0, 4'd0);
      drive(1'b1, tx_body[i], i == er_idx);
    end
    if (accepted && n >= 5) push_beat(tx_body[n-5], 1'b1, st);
    drive(1'b0, 8'h00, 1'b0);
    if (accepted && n >= 5 && st == 4'd0) begin
      if (exp_ok < 65535) exp_ok++;
    end else begin
      if (exp_bad < 65535) exp_bad++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int plen;
    int er;
    int lens[4];
    rst_n = 1'b0; gmii_rx_dv = 1'b0; gmii_rxd = 8'h00; gmii_rx_er = 1'b0;
    repeat (3) @(posedge gmii_rx_clk);
    #1 rst_n = 1'b1;
    idle(2);

    tx_body = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    req("crc_model_pin", 5, 64'h CBF43926, 64'(crc32_of(9)));

    mark(); set_pre(7); set_seq(60); add_fcs(); send_frame(-1, -1); idle(2);
    req("good_beats", 0, 60); req("good_status", 1, 0); req("good_ok", 2, 1);

    mark(); set_pre(7); set_seq(60); add_fcs(); tx_body[10] = tx_body[10] ^ 8'hFF;
    send_frame(-1, -1); idle(2);
    req("crc_beats", 0, 60); req("crc_status", 1, 4'b1000); req("crc_bad", 3, 1);

    mark(); set_pre(7); set_seq(60); add_fcs(); send_frame(20, -1); idle(2);
    req("phy_status", 1, 4'b0001); req("phy_bad", 3, 2);

    mark(); set_pre(7); set_seq(30); add_fcs(); send_frame(-1, -1); idle(2);
    req("runt_beats", 0, 30); req("runt_status", 1, 4'b0010); req("runt_bad", 3, 3);

    mark(); set_pre(7); set_seq(3); send_frame(-1, -1); idle(2);
    req("tiny_beats", 0, 0); req("tiny_bad", 3, 4);

    mark(); set_pre(7); set_rand(1596); add_fcs(); send_frame(-1, -1); idle(2);
    req("long_beats", 0, 1596); req("long_status", 1, 4'b0100); req("long_bad", 3, 5);

    mark(); tx_pre = '{8'h55, 8'h55, 8'h12}; set_seq(10); send_frame(-1, -1); idle(2);
    req("drop_beats", 0, 0); req("drop_bad", 3, 6);

    mark();
    set_pre(7); set_rand(60); add_fcs(); send_frame(-1, -1);
    set_pre(7); set_rand(60); add_fcs(); send_frame(-1, -1); idle(2);
    req("b2b_beats", 0, 120); req("b2b_ok", 2, 3);

    set_pre(7); set_seq(60); add_fcs(); send_frame(-1, 30);
    mark(); set_pre(7); set_seq(60); add_fcs(); send_frame(-1, -1); idle(2);
    req("rst_beats", 0, 60); req("rst_ok", 2, 1); req("rst_bad", 3, 0);

    lens = '{59, 60, 1514, 1515};
    foreach (lens[i]) begin
      set_pre(7); set_rand(lens[i]); add_fcs(); send_frame(-1, -1);
    end

    for (int f = 0; f < 30; f++) begin
      plen = $urandom_range(0, 120);
      set_pre($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0)
        tx_pre[$urandom_range(0, tx_pre.size() - 1)] = ($urandom_range(0, 1) != 0) ? 8'hAA : 8'h12;
      set_rand(plen);
      add_fcs();
      if ($urandom_range(0, 5) == 0) tx_body[$urandom_range(0, tx_body.size() - 1)] ^= 8'h01;
      er = ($urandom_range(0, 7) == 0) ? $urandom_range(0, tx_body.size() - 1) : -1;
      send_frame(er, -1);
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3));
    end

    idle(4);
    req("all_beats_delivered", 4, 0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
